// File: rtl/n2_issue_sched_pkg.sv
// n2_issue_sched_pkg: shared types, depth and helpers for the dual-issue scheduler
package n2_issue_sched_pkg;
    localparam int regindex_bits = 5;
    localparam int ISSUE_DEPTH = 4;
    typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;
    typedef struct packed {
        logic [regindex_bits-1:0] rd;
        alu_op_t alu_op;
        logic is_beq_bne_blt_bge_bltu_bgeu;
        logic instr_jalr;
    } uop_ctl_t;
    typedef struct packed {
        logic [7:0] uid;
        logic [31:0] pc;
        uop_ctl_t uop;
        logic [regindex_bits-1:0] rs1;
        logic [regindex_bits-1:0] rs2;
    } issue_pkt_t;
    function automatic logic is_ctrl_flow(uop_ctl_t u);
        return u.is_beq_bne_blt_bge_bltu_bgeu || u.instr_jalr;
    endfunction
endpackage

// File: rtl/n2_issue_sched_if.sv
// n2_issue_sched_if: decode-side push bundle and per-lane execute issue bundle
interface n2_issue_sched_if;
    import n2_issue_sched_pkg::*;
    logic [1:0] in_v_i;
    issue_pkt_t [1:0] in_pkt_i;
    logic in_ready_o;
    logic [1:0] to_ex_v_o;
    logic [1:0][7:0] uid_o;
    logic [1:0][31:0] pc_o;
    uop_ctl_t [1:0] uop_o;
    modport master (output in_v_i, in_pkt_i, input in_ready_o, to_ex_v_o, uid_o, pc_o, uop_o);
    modport slave (input in_v_i, in_pkt_i, output in_ready_o, to_ex_v_o, uid_o, pc_o, uop_o);
endinterface

// File: rtl/n2_issue_fifo.sv
// n2_issue_fifo: 2-write/2-read circular buffer exposing head and next entries
module n2_issue_fifo import n2_issue_sched_pkg::*; #(
    parameter int DEPTH = ISSUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic [1:0] push_n,
    input  logic [1:0] pop_n,
    input  issue_pkt_t wr0,
    input  issue_pkt_t wr1,
    output issue_pkt_t head,
    output issue_pkt_t nxt,
    output logic [PTR_W:0] occ
);
    issue_pkt_t mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr, wptr1, rptr1;
    assign wptr1 = wptr + 1'b1;
    assign rptr1 = rptr + 1'b1;
    assign head = mem[rptr];
    assign nxt = mem[rptr1];
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wptr] <= wr0;
        if (push_n == 2'd2) mem[wptr1] <= wr1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ <= '0;
        end else if (flush) begin
            rptr <= wptr;
            occ <= '0;
        end else begin
            wptr <= wptr + PTR_W'(push_n);
            rptr <= rptr + PTR_W'(pop_n);
            occ <= occ + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
    end
endmodule

// File: rtl/n2_issue_sched.sv
// n2_issue_sched: dual-issue in-order scheduler between decode and two execute lanes
module n2_issue_sched import n2_issue_sched_pkg::*; #(
    parameter int DEPTH = ISSUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    n2_issue_sched_if.slave bus,
    input  logic stall_i,
    input  logic flush_i,
    output logic [31:0] dual_cnt_o,
    output logic [PTR_W:0] occ_o
);
    issue_pkt_t head, nxt;
    logic [1:0] push_n, pop_n;
    logic acc0, acc1, issue0, issue1, hazard;
    assign bus.in_ready_o = !rst && !flush_i && occ_o <= (PTR_W+1)'(DEPTH-2);
    assign acc0 = bus.in_v_i[0] && bus.in_ready_o;
    assign acc1 = acc0 && bus.in_v_i[1];
    assign push_n = {1'b0, acc0} + {1'b0, acc1};
    // x0 never creates a dependency, so a zero rd is exempt from RAW/WAW splitting
    assign hazard = head.uop.rd != '0 &&
                    (head.uop.rd == nxt.rs1 || head.uop.rd == nxt.rs2 || head.uop.rd == nxt.uop.rd);
    assign issue0 = occ_o != '0;
    assign issue1 = issue0 && occ_o >= (PTR_W+1)'(2) && !is_ctrl_flow(head.uop) &&
                    !is_ctrl_flow(nxt.uop) && !hazard;
    assign pop_n = (stall_i || flush_i) ? 2'd0 : {1'b0, issue0} + {1'b0, issue1};
    n2_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(flush_i), .push_n(push_n), .pop_n(pop_n),
        .wr0(bus.in_pkt_i[0]), .wr1(bus.in_pkt_i[1]), .head(head), .nxt(nxt), .occ(occ_o)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.to_ex_v_o <= '0;
            dual_cnt_o <= '0;
        end else if (flush_i) begin
            bus.to_ex_v_o <= '0;
        end else if (!stall_i) begin
            bus.to_ex_v_o <= {issue1, issue0};
            dual_cnt_o <= dual_cnt_o + 32'(issue1);
            bus.uid_o[0] <= head.uid;
            bus.pc_o[0] <= head.pc;
            bus.uop_o[0] <= head.uop;
            if (issue1) begin
                bus.uid_o[1] <= nxt.uid;
                bus.pc_o[1] <= nxt.pc;
                bus.uop_o[1] <= nxt.uop;
            end
        end
    end
endmodule

// File: tb/tb_n2_issue_sched.sv
// tb_n2_issue_sched: directed self-checking bench for the dual-issue scheduler
module tb_n2_issue_sched;
    import n2_issue_sched_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic [31:0] dual_cnt;
    logic [2:0] occ;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dual = 0;
    n2_issue_sched_if bus();
    n2_issue_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall_i(stall), .flush_i(flush),
        .dual_cnt_o(dual_cnt), .occ_o(occ)
    );
    always #5 clk = ~clk;

    function automatic issue_pkt_t mk(input logic [7:0] uid, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic br, input logic jr);
        issue_pkt_t p;
        p.uid = uid;
        p.pc = 32'(uid) * 32'd4;
        p.uop.rd = rd;
        p.uop.alu_op = ALU_ADD;
        p.uop.is_beq_bne_blt_bge_bltu_bgeu = br;
        p.uop.instr_jalr = jr;
        p.rs1 = rs1;
        p.rs2 = rs2;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input issue_pkt_t p0, input issue_pkt_t p1);
        bus.in_v_i = v;
        bus.in_pkt_i[0] = p0;
        bus.in_pkt_i[1] = p1;
    endtask

    task automatic idle();
        bus.in_v_i = 2'b00;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
        checks++; if (bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL rst_v got %b exp 00", bus.to_ex_v_o); end
        checks++; if (dual_cnt !== 32'd0) begin errors++; $display("FAIL rst_dual got %0d exp 0", dual_cnt); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.in_ready_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", bus.in_ready_o); end
    endtask

    task automatic test_independent();
        drive(2'b11, mk(1, 1, 0, 0, 0, 0), mk(2, 2, 0, 0, 0, 0));
        tick();
        idle();
        checks++; if (occ !== 3'd2) begin errors++; $display("FAIL ind_occ1 got %0d exp 2", occ); end
        checks++; if (bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL ind_lat got %b exp 00", bus.to_ex_v_o); end
        tick();
        exp_dual = 1;
        checks++; if (bus.to_ex_v_o !== 2'b11) begin errors++; $display("FAIL ind_v got %b exp 11", bus.to_ex_v_o); end
        checks++; if (bus.uid_o[0] !== 8'd1 || bus.uid_o[1] !== 8'd2) begin errors++; $display("FAIL ind_uid got %0d/%0d exp 1/2", bus.uid_o[0], bus.uid_o[1]); end
        checks++; if (bus.pc_o[1] !== 32'd8) begin errors++; $display("FAIL ind_pc1 got %0d exp 8", bus.pc_o[1]); end
        checks++; if (dual_cnt !== exp_dual) begin errors++; $display("FAIL ind_dual got %0d exp %0d", dual_cnt, exp_dual); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL ind_occ2 got %0d exp 0", occ); end
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL ind_idle got %b exp 00", bus.to_ex_v_o); end
    endtask

    task automatic test_raw();
        drive(2'b11, mk(3, 5, 1, 2, 0, 0), mk(4, 6, 5, 3, 0, 0));
        tick();
        idle();
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b01 || bus.uid_o[0] !== 8'd3) begin errors++; $display("FAIL raw_first got %b/%0d exp 01/3", bus.to_ex_v_o, bus.uid_o[0]); end
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b01 || bus.uid_o[0] !== 8'd4) begin errors++; $display("FAIL raw_second got %b/%0d exp 01/4", bus.to_ex_v_o, bus.uid_o[0]); end
        checks++; if (dual_cnt !== exp_dual) begin errors++; $display("FAIL raw_dual got %0d exp %0d", dual_cnt, exp_dual); end
        tick();
    endtask

    task automatic test_branch();
        drive(2'b11, mk(5, 0, 1, 2, 1, 0), mk(6, 7, 0, 0, 0, 0));
        tick();
        idle();
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b01 || bus.uid_o[0] !== 8'd5) begin errors++; $display("FAIL br_alone got %b/%0d exp 01/5", bus.to_ex_v_o, bus.uid_o[0]); end
        checks++; if (bus.uop_o[0].is_beq_bne_blt_bge_bltu_bgeu !== 1'b1) begin errors++; $display("FAIL br_uop got %b exp 1", bus.uop_o[0].is_beq_bne_blt_bge_bltu_bgeu); end
        drive(2'b11, mk(7, 8, 0, 0, 0, 0), mk(8, 9, 0, 0, 0, 0));
        tick();
        idle();
        checks++; if (bus.to_ex_v_o !== 2'b01 || bus.uid_o[0] !== 8'd6) begin errors++; $display("FAIL br_next got %b/%0d exp 01/6", bus.to_ex_v_o, bus.uid_o[0]); end
        tick();
        exp_dual = 2;
        checks++; if (bus.to_ex_v_o !== 2'b11 || bus.uid_o[0] !== 8'd7 || bus.uid_o[1] !== 8'd8) begin errors++; $display("FAIL br_pair got %b/%0d/%0d exp 11/7/8", bus.to_ex_v_o, bus.uid_o[0], bus.uid_o[1]); end
        checks++; if (dual_cnt !== exp_dual) begin errors++; $display("FAIL br_dual got %0d exp %0d", dual_cnt, exp_dual); end
        tick();
    endtask

    task automatic test_pair_rules();
        issue_pkt_t h [5];
        issue_pkt_t n [5];
        logic [1:0] ev [5];
        h[0] = mk(10, 0, 1, 0, 0, 0); n[0] = mk(11, 0, 0, 0, 0, 0); ev[0] = 2'b11;
        h[1] = mk(12, 4, 0, 0, 0, 0); n[1] = mk(13, 4, 0, 0, 0, 0); ev[1] = 2'b01;
        h[2] = mk(14, 5, 0, 0, 0, 0); n[2] = mk(15, 6, 0, 0, 0, 1); ev[2] = 2'b01;
        h[3] = mk(16, 1, 0, 0, 0, 1); n[3] = mk(17, 6, 0, 0, 0, 0); ev[3] = 2'b01;
        h[4] = mk(18, 9, 0, 0, 0, 0); n[4] = mk(19, 10, 1, 9, 0, 0); ev[4] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, h[i], n[i]);
            tick();
            idle();
            tick();
            if (ev[i] == 2'b11) exp_dual++;
            checks++; if (bus.to_ex_v_o !== ev[i] || bus.uid_o[0] !== h[i].uid) begin errors++; $display("FAIL rule%0d got %b/%0d exp %b/%0d", i, bus.to_ex_v_o, bus.uid_o[0], ev[i], h[i].uid); end
            tick();
            tick();
        end
        checks++; if (dual_cnt !== exp_dual) begin errors++; $display("FAIL rule_dual got %0d exp %0d", dual_cnt, exp_dual); end
    endtask

    task automatic test_full();
        stall = 1'b1;
        drive(2'b11, mk(20, 11, 0, 0, 0, 0), mk(21, 12, 0, 0, 0, 0));
        tick();
        drive(2'b11, mk(22, 13, 0, 0, 0, 0), mk(23, 14, 0, 0, 0, 0));
        tick();
        checks++; if (occ !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occ); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.in_ready_o); end
        drive(2'b11, mk(24, 15, 0, 0, 0, 0), mk(25, 16, 0, 0, 0, 0));
        tick();
        checks++; if (occ !== 3'd4) begin errors++; $display("FAIL full_drop got %0d exp 4", occ); end
        checks++; if (bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL full_hold got %b exp 00", bus.to_ex_v_o); end
        idle();
        stall = 1'b0;
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b11 || bus.uid_o[0] !== 8'd20 || bus.uid_o[1] !== 8'd21) begin errors++; $display("FAIL drain1 got %b/%0d/%0d exp 11/20/21", bus.to_ex_v_o, bus.uid_o[0], bus.uid_o[1]); end
        checks++; if (occ !== 3'd2) begin errors++; $display("FAIL drain1_occ got %0d exp 2", occ); end
        tick();
        exp_dual += 2;
        checks++; if (bus.to_ex_v_o !== 2'b11 || bus.uid_o[0] !== 8'd22 || bus.uid_o[1] !== 8'd23) begin errors++; $display("FAIL drain2 got %b/%0d/%0d exp 11/22/23", bus.to_ex_v_o, bus.uid_o[0], bus.uid_o[1]); end
        checks++; if (occ !== 3'd0 || dual_cnt !== exp_dual) begin errors++; $display("FAIL drain2_occ_dual got %0d/%0d exp 0/%0d", occ, dual_cnt, exp_dual); end
        tick();
    endtask

    task automatic test_flush();
        drive(2'b11, mk(30, 5, 0, 0, 0, 0), mk(31, 6, 5, 0, 0, 0));
        tick();
        drive(2'b11, mk(32, 7, 0, 0, 0, 0), mk(33, 8, 0, 0, 0, 0));
        tick();
        idle();
        checks++; if (occ !== 3'd3 || bus.to_ex_v_o !== 2'b01 || bus.uid_o[0] !== 8'd30) begin errors++; $display("FAIL fl_pre got %0d/%b/%0d exp 3/01/30", occ, bus.to_ex_v_o, bus.uid_o[0]); end
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_occ3_ready got %b exp 0", bus.in_ready_o); end
        flush = 1'b1;
        drive(2'b11, mk(34, 9, 0, 0, 0, 0), mk(35, 10, 0, 0, 0, 0));
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", bus.in_ready_o); end
        tick();
        flush = 1'b0;
        idle();
        checks++; if (bus.to_ex_v_o !== 2'b00 || occ !== 3'd0) begin errors++; $display("FAIL fl_post got %b/%0d exp 00/0", bus.to_ex_v_o, occ); end
        checks++; if (dual_cnt !== exp_dual) begin errors++; $display("FAIL fl_dual got %0d exp %0d", dual_cnt, exp_dual); end
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL fl_ghost got %b exp 00", bus.to_ex_v_o); end
        flush = 1'b1;
        drive(2'b11, mk(36, 11, 0, 0, 0, 0), mk(37, 12, 0, 0, 0, 0));
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_empty_ready got %b exp 0", bus.in_ready_o); end
        tick();
        flush = 1'b0;
        idle();
        tick();
        checks++; if (occ !== 3'd0 || bus.to_ex_v_o !== 2'b00) begin errors++; $display("FAIL fl_empty_post got %0d/%b exp 0/00", occ, bus.to_ex_v_o); end
        drive(2'b11, mk(38, 13, 0, 0, 0, 0), mk(39, 14, 0, 0, 0, 0));
        tick();
        idle();
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b11 || bus.uid_o[0] !== 8'd38 || bus.uid_o[1] !== 8'd39) begin errors++; $display("FAIL fl_resume got %b/%0d/%0d exp 11/38/39", bus.to_ex_v_o, bus.uid_o[0], bus.uid_o[1]); end
        tick();
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        drive(2'b11, mk(40, 5, 0, 0, 0, 0), mk(41, 6, 0, 0, 0, 0));
        tick();
        idle();
        checks++; if (occ !== 3'd2) begin errors++; $display("FAIL rm_pre got %0d exp 2", occ); end
        rst = 1'b1;
        tick();
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL rm_ready got %b exp 0", bus.in_ready_o); end
        rst = 1'b0;
        stall = 1'b0;
        checks++; if (occ !== 3'd0 || bus.to_ex_v_o !== 2'b00 || dual_cnt !== 32'd0) begin errors++; $display("FAIL rm_post got %0d/%b/%0d exp 0/00/0", occ, bus.to_ex_v_o, dual_cnt); end
        drive(2'b11, mk(42, 7, 0, 0, 0, 0), mk(43, 8, 0, 0, 0, 0));
        tick();
        idle();
        tick();
        checks++; if (bus.to_ex_v_o !== 2'b11 || bus.uid_o[0] !== 8'd42 || bus.uid_o[1] !== 8'd43) begin errors++; $display("FAIL rm_push got %b/%0d/%0d exp 11/42/43", bus.to_ex_v_o, bus.uid_o[0], bus.uid_o[1]); end
        checks++; if (dual_cnt !== 32'd1) begin errors++; $display("FAIL rm_dual got %0d exp 1", dual_cnt); end
    endtask

    initial begin
        bus.in_v_i = 2'b00;
        bus.in_pkt_i = '0;
        test_reset();
        test_independent();
        test_raw();
        test_branch();
        test_pair_rules();
        test_full();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
